wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares one pipelined Wishbone master port between the L1d read-write requester and the L1i read-only requester.
- The shared port feeds the memory system's bank decoder.
- RW has priority at arbitration time. RO is protected by an anti-starvation counter.
- Per-grant limits: bounded outstanding transactions, plus a watchdog that converts a hung slave into a bus error.

Parameters:
- AW, 32, address width.
- MW, 64, data width.
- BW, MW/8, byte-enable width.
- MAX_OUT, 4, maximum outstanding (accepted, unacknowledged) requests per grant.
- STARVE_LIMIT, 8, cycles RO may wait while RW is granted before RW is preempted.
- TIMEOUT, 255, cycles with outstanding>0 and no ack/err before a forced error.

Ports:
- i_clk in 1: clock.
- i_reset in 1: reset, asynchronous, active-high.
- i_rw_cyc, i_rw_stb, i_rw_we in 1 each: L1d Wishbone cycle, strobe, write enable.
- i_rw_addr in AW; i_rw_data in MW; i_rw_be in BW: L1d request fields.
- o_rw_stall, o_rw_ack, o_rw_err out 1 each; o_rw_data out MW: L1d responses.
- i_ro_cyc, i_ro_stb in 1 each; i_ro_addr in AW: L1i request.
- o_ro_stall, o_ro_ack, o_ro_err out 1 each; o_ro_data out MW: L1i responses.
- o_wb_cyc, o_wb_stb, o_wb_we out 1 each; o_wb_addr out AW; o_wb_data out MW; o_wb_be out BW: shared master port.
- i_wb_stall, i_wb_ack, i_wb_err in 1 each; i_wb_data in MW: shared port responses.
- o_grant out 2: 2'b01 = RW granted, 2'b10 = RO granted, 2'b00 = none.

Behaviour:
- Single clock; i_reset is asynchronous and active-high.
- Reset values: state IDLE, outstanding=0, starve_cnt=0, wdog=0.
  - o_wb_cyc=0, o_wb_stb=0, all acks/errs=0, both stalls=1, o_grant=0.
- States: IDLE, RW, RO, ERR. The state register is updated only on the clock edge.
- IDLE:
  - o_wb_cyc=0; both stalls=1.
  - Go to RW if i_rw_cyc && !(i_ro_cyc && starve_cnt==STARVE_LIMIT).
  - Otherwise go to RO if i_ro_cyc.
  - Otherwise stay in IDLE.
  - A grant is visible one cycle after the cyc request.
- Granted state X (RW or RO):
  - o_wb_cyc=1.
  - o_wb_stb = i_x_stb && !cap, where cap = (outstanding==MAX_OUT) || preempt.
  - o_x_stall = i_wb_stall || cap; the non-granted stall=1.
- Request fields pass through combinationally from the granted requester.
  - RO grant drives o_wb_we=0, o_wb_be=all ones, o_wb_data=0.
  - IDLE/ERR drive addr/data/be=0 and we=0.
- Response routing:
  - o_x_ack=i_wb_ack and o_x_err=i_wb_err, gated by the grant; the non-granted requester's ack/err stay 0.
  - o_rw_data/o_ro_data = i_wb_data when granted, else 0.
- outstanding (clog2(MAX_OUT+1) bits):
  - +1 on o_wb_stb && !i_wb_stall; -1 on i_wb_ack; both in one cycle = no change.
  - Never exceeds MAX_OUT.
  - Cleared when leaving a granted state.
- Release: i_x_cyc low while granted -> IDLE next cycle, outstanding cleared. Wishbone abort; late acks are ignored because cyc=0.
- Error: i_wb_err while granted is forwarded to the granted requester -> ERR.
  - ERR: o_wb_cyc=0, o_x_stall=1; stay until i_x_cyc low, then IDLE.
- Watchdog:
  - wdog increments each granted cycle with outstanding>0 && !i_wb_ack && !i_wb_err; otherwise it clears.
  - At wdog==TIMEOUT: pulse o_x_err for one cycle -> ERR; wdog cleared.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle in RW with i_ro_cyc=1.
  - Cleared on entering RO, or when i_ro_cyc=0.
- Preemption: preempt = (state==RW && starve_cnt==STARVE_LIMIT).
  - While preempt, RW is stalled.
  - Once outstanding==0, go to IDLE (o_wb_cyc low for one cycle), then RO is chosen.
  - RW keeps its cyc and resumes after RO releases.
- RO is never preempted.
- Simultaneous i_wb_ack and i_wb_err: error wins; the ack is still forwarded, and no decrement is needed since the counter is cleared.
- Reset mid-transfer: immediate IDLE with all outputs at reset values; no ack is owed.

Test Plan:
- Reset then both cyc=1 on the same cycle -> o_grant=2'b01 on the next cycle; RW stb with addr 0x20000010 appears on o_wb_addr unchanged; o_ro_stall=1.
- RO alone, 4 stb with i_wb_ack withheld, MAX_OUT=4 -> o_wb_stb drops and o_ro_stall=1 on the 5th request; one ack -> a 5th request is accepted.
- RW holds cyc continuously with ro waiting -> after 8 cycles RW is stalled; once outstanding=0, o_wb_cyc=0 for one cycle, then o_grant=2'b10.
- RO granted, 1 stb accepted, no response for 255 cycles -> o_ro_err pulses one cycle, o_wb_cyc=0; ERR held until i_ro_cyc=0, then IDLE.
- RW write with i_wb_err returned -> o_rw_err=1 the same cycle, o_ro_err=0; the next RW stb is stalled until cyc is dropped and re-raised.
- Assert i_reset asynchronously with 2 outstanding -> o_wb_cyc=0 immediately (before the clock edge), both stalls=1; the next ack from the slave produces no o_*_ack.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the L1d/L1i requesters, the arbiter and the shared Wishbone port.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface wb_port_arbiter_if #(
    parameter int AW = 32,
    parameter int MW = 64
);
    localparam int BW = MW / 8;

    logic          i_rw_cyc;
    logic          i_rw_stb;
    logic          i_rw_we;
    logic [AW-1:0] i_rw_addr;
    logic [MW-1:0] i_rw_data;
    logic [BW-1:0] i_rw_be;
    logic          o_rw_stall;
    logic          o_rw_ack;
    logic          o_rw_err;
    logic [MW-1:0] o_rw_data;

    logic          i_ro_cyc;
    logic          i_ro_stb;
    logic [AW-1:0] i_ro_addr;
    logic          o_ro_stall;
    logic          o_ro_ack;
    logic          o_ro_err;
    logic [MW-1:0] o_ro_data;

    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [MW-1:0] o_wb_data;
    logic [BW-1:0] o_wb_be;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [MW-1:0] i_wb_data;

    logic [1:0]    o_grant;

    modport master (
        input  i_rw_cyc, i_rw_stb, i_rw_we, i_rw_addr, i_rw_data, i_rw_be,
        output o_rw_stall, o_rw_ack, o_rw_err, o_rw_data,
        input  i_ro_cyc, i_ro_stb, i_ro_addr,
        output o_ro_stall, o_ro_ack, o_ro_err, o_ro_data,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_be,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_grant
    );

    modport slave (
        output i_rw_cyc, i_rw_stb, i_rw_we, i_rw_addr, i_rw_data, i_rw_be,
        input  o_rw_stall, o_rw_ack, o_rw_err, o_rw_data,
        output i_ro_cyc, i_ro_stb, i_ro_addr,
        input  o_ro_stall, o_ro_ack, o_ro_err, o_ro_data,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_be,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_grant
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates one pipelined Wishbone port between L1d (RW, priority) and L1i (RO),
// with RO anti-starvation preemption, an outstanding-request cap and a hung-slave watchdog.
//
// state | meaning
// IDLE  | no grant, port cycle low, both requesters stalled
// RW    | L1d owns the port
// RO    | L1i owns the port
// ERR   | bus error delivered; owner stalled until it drops cyc
module wb_port_arbiter #(
    parameter int AW           = 32,
    parameter int MW           = 64,
    parameter int BW           = MW / 8,
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wb_port_arbiter_if.master bus
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RW   = 2'd1,
        S_RO   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [OW-1:0] r_out;
    logic [OW-1:0] w_out_nxt;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] w_starve_nxt;
    logic [TW-1:0] r_wdog;
    logic [TW-1:0] w_wdog_nxt;
    logic          r_err_rw;

    logic w_gnt_rw;
    logic w_gnt_ro;
    logic w_gnt;
    logic w_preempt;
    logic w_cap;
    logic w_wdog_fire;
    logic w_x_cyc;
    logic w_x_stb;
    logic w_inc;
    logic w_dec;
    logic w_stay;

    assign w_gnt_rw    = (r_state == S_RW);
    assign w_gnt_ro    = (r_state == S_RO);
    assign w_gnt       = w_gnt_rw || w_gnt_ro;
    assign w_preempt   = w_gnt_rw && (r_starve == SW'(STARVE_LIMIT));
    assign w_cap       = (r_out == OW'(MAX_OUT)) || w_preempt;
    assign w_wdog_fire = w_gnt && (r_wdog == TW'(TIMEOUT));
    assign w_x_cyc     = w_gnt_rw ? bus.i_rw_cyc : bus.i_ro_cyc;
    assign w_x_stb     = w_gnt_rw ? bus.i_rw_stb : bus.i_ro_stb;

    assign bus.o_wb_cyc  = w_gnt;
    assign bus.o_wb_stb  = w_gnt && w_x_stb && !w_cap;
    assign bus.o_wb_we   = w_gnt_rw && bus.i_rw_we;
    assign bus.o_wb_addr = w_gnt_rw ? bus.i_rw_addr : (w_gnt_ro ? bus.i_ro_addr : '0);
    assign bus.o_wb_data = w_gnt_rw ? bus.i_rw_data : '0;
    assign bus.o_wb_be   = w_gnt_rw ? bus.i_rw_be : (w_gnt_ro ? {BW{1'b1}} : '0);

    assign bus.o_rw_stall = w_gnt_rw ? (bus.i_wb_stall || w_cap) : 1'b1;
    assign bus.o_ro_stall = w_gnt_ro ? (bus.i_wb_stall || w_cap) : 1'b1;
    assign bus.o_rw_ack   = w_gnt_rw && bus.i_wb_ack;
    assign bus.o_ro_ack   = w_gnt_ro && bus.i_wb_ack;
    assign bus.o_rw_err   = w_gnt_rw && (bus.i_wb_err || w_wdog_fire);
    assign bus.o_ro_err   = w_gnt_ro && (bus.i_wb_err || w_wdog_fire);
    assign bus.o_rw_data  = w_gnt_rw ? bus.i_wb_data : '0;
    assign bus.o_ro_data  = w_gnt_ro ? bus.i_wb_data : '0;
    assign bus.o_grant    = {w_gnt_ro, w_gnt_rw};

    assign w_inc  = bus.o_wb_stb && !bus.i_wb_stall;
    assign w_dec  = bus.i_wb_ack && (r_out != '0);
    assign w_stay = w_gnt && (w_state_nxt == r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_rw_cyc && !(bus.i_ro_cyc && (r_starve == SW'(STARVE_LIMIT))))
                    w_state_nxt = S_RW;
                else if (bus.i_ro_cyc)
                    w_state_nxt = S_RO;
            end
            S_RW, S_RO: begin
                if (!w_x_cyc)
                    w_state_nxt = S_IDLE;
                else if (bus.i_wb_err || w_wdog_fire)
                    w_state_nxt = S_ERR;
                else if (w_preempt && (r_out == '0))
                    w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (!(r_err_rw ? bus.i_rw_cyc : bus.i_ro_cyc))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt = '0;
        if (w_stay) begin
            case ({w_inc, w_dec})
                2'b10:   w_out_nxt = r_out + OW'(1);
                2'b01:   w_out_nxt = r_out - OW'(1);
                default: w_out_nxt = r_out;
            endcase
        end
    end

    // Watchdog only runs while the owner is waiting on a slave with nothing coming back.
    always_comb begin
        w_wdog_nxt = '0;
        if (w_stay && (r_out != '0) && !bus.i_wb_ack && !bus.i_wb_err)
            w_wdog_nxt = r_wdog + TW'(1);
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (!bus.i_ro_cyc)
            w_starve_nxt = '0;
        else if ((w_state_nxt == S_RO) && (r_state != S_RO))
            w_starve_nxt = '0;
        else if (w_gnt_rw && (r_starve != SW'(STARVE_LIMIT)))
            w_starve_nxt = r_starve + SW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_starve <= '0;
            r_wdog   <= '0;
            r_err_rw <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_starve <= w_starve_nxt;
            r_wdog   <= w_wdog_nxt;
            if ((w_state_nxt == S_ERR) && (r_state != S_ERR))
                r_err_rw <= w_gnt_rw;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: grant order, outstanding cap, preemption,
// watchdog, bus error and asynchronous reset, all against hand-computed values.
module tb_wb_port_arbiter;
    logic i_clk;
    logic i_reset;
    int   n_checks;
    int   n_errors;
    int   k;

    wb_port_arbiter_if #(.AW(32), .MW(64)) bus ();

    wb_port_arbiter #(
        .AW(32), .MW(64), .MAX_OUT(4), .STARVE_LIMIT(8), .TIMEOUT(255)
    ) u_dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_rw_cyc   = 1'b0;
        bus.i_rw_stb   = 1'b0;
        bus.i_rw_we    = 1'b0;
        bus.i_rw_addr  = '0;
        bus.i_rw_data  = '0;
        bus.i_rw_be    = '0;
        bus.i_ro_cyc   = 1'b0;
        bus.i_ro_stb   = 1'b0;
        bus.i_ro_addr  = '0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_data  = '0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        i_reset = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        check("rst_grant",    64'(bus.o_grant),    64'h0);
        check("rst_cyc",      64'(bus.o_wb_cyc),   64'h0);
        check("rst_stb",      64'(bus.o_wb_stb),   64'h0);
        check("rst_rw_stall", 64'(bus.o_rw_stall), 64'h1);
        check("rst_ro_stall", 64'(bus.o_ro_stall), 64'h1);
        check("rst_acks",     64'({bus.o_rw_ack, bus.o_ro_ack, bus.o_rw_err, bus.o_ro_err}), 64'h0);

        // Both request together: RW wins, RO starts accumulating starvation.
        bus.i_rw_cyc  = 1'b1;
        bus.i_ro_cyc  = 1'b1;
        bus.i_rw_stb  = 1'b1;
        bus.i_rw_addr = 32'h2000_0010;
        #1;
        check("idle_no_cyc",  64'(bus.o_wb_cyc), 64'h0);
        check("idle_no_stb",  64'(bus.o_wb_stb), 64'h0);
        tick();
        check("both_grant",   64'(bus.o_grant),    64'h1);
        check("rw_addr",      64'(bus.o_wb_addr),  64'h2000_0010);
        check("rw_stb",       64'(bus.o_wb_stb),   64'h1);
        check("ro_stall_rw",  64'(bus.o_ro_stall), 64'h1);
        check("rw_not_stall", 64'(bus.o_rw_stall), 64'h0);
        tick();
        bus.i_rw_stb = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_starve_stall", 64'(bus.o_rw_stall), 64'h0);
        check("pre_starve_cyc",   64'(bus.o_wb_cyc),   64'h1);
        tick();
        bus.i_rw_stb = 1'b1;
        #1;
        check("preempt_stall", 64'(bus.o_rw_stall), 64'h1);
        check("preempt_stb",   64'(bus.o_wb_stb),   64'h0);
        check("preempt_grant", 64'(bus.o_grant),    64'h1);
        bus.i_wb_ack  = 1'b1;
        bus.i_wb_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("preempt_ack",  64'(bus.o_rw_ack),  64'h1);
        check("rw_rdata",     bus.o_rw_data,      64'hDEAD_BEEF_0123_4567);
        check("ro_rdata_off", bus.o_ro_data,      64'h0);
        tick();
        bus.i_wb_ack  = 1'b0;
        bus.i_wb_data = '0;
        #1;
        check("drain_grant", 64'(bus.o_grant),  64'h1);
        check("drain_cyc",   64'(bus.o_wb_cyc), 64'h1);
        tick();
        check("gap_cyc",   64'(bus.o_wb_cyc), 64'h0);
        check("gap_grant", 64'(bus.o_grant),  64'h0);
        tick();
        check("ro_after_preempt", 64'(bus.o_grant),    64'h2);
        check("rw_stall_in_ro",   64'(bus.o_rw_stall), 64'h1);
        bus.i_ro_cyc = 1'b0;
        tick();
        check("ro_release", 64'(bus.o_grant), 64'h0);
        tick();
        check("rw_resume",  64'(bus.o_grant), 64'h1);
        bus.i_rw_stb = 1'b0;
        bus.i_rw_cyc = 1'b0;
        tick();

        // Outstanding cap with RO alone.
        do_reset();
        bus.i_ro_cyc  = 1'b1;
        tick();
        check("ro_grant", 64'(bus.o_grant), 64'h2);
        bus.i_ro_stb  = 1'b1;
        bus.i_ro_addr = 32'h0000_4000;
        #1;
        check("ro_be",   64'(bus.o_wb_be),   64'hFF);
        check("ro_we",   64'(bus.o_wb_we),   64'h0);
        check("ro_addr", 64'(bus.o_wb_addr), 64'h4000);
        for (int i = 0; i < 4; i++) begin
            check("ro_cap_stb", 64'(bus.o_wb_stb), 64'h1);
            tick();
        end
        check("cap5_stb",   64'(bus.o_wb_stb),   64'h0);
        check("cap5_stall", 64'(bus.o_ro_stall), 64'h1);
        bus.i_wb_ack = 1'b1;
        #1;
        check("cap_ack_fwd",   64'(bus.o_ro_ack), 64'h1);
        check("cap_ack_stall", 64'(bus.o_ro_stall), 64'h1);
        tick();
        bus.i_wb_ack = 1'b0;
        #1;
        check("after_ack_stb",   64'(bus.o_wb_stb),   64'h1);
        check("after_ack_stall", 64'(bus.o_ro_stall), 64'h0);
        tick();
        bus.i_ro_stb = 1'b0;
        bus.i_ro_cyc = 1'b0;
        tick();
        check("ro_abort_idle", 64'(bus.o_grant), 64'h0);
        bus.i_wb_ack = 1'b1;
        #1;
        check("late_ack", 64'({bus.o_rw_ack, bus.o_ro_ack}), 64'h0);
        bus.i_wb_ack = 1'b0;

        // Watchdog: one accepted RO request that never completes.
        do_reset();
        bus.i_ro_cyc = 1'b1;
        tick();
        bus.i_ro_stb = 1'b1;
        tick();
        bus.i_ro_stb = 1'b0;
        #1;
        k = 0;
        while (!bus.o_ro_err && k < 300) begin
            tick();
            k++;
        end
        check("wdog_cycles", 64'(k), 64'd255);
        check("wdog_rw_err", 64'(bus.o_rw_err), 64'h0);
        tick();
        check("wdog_pulse",  64'(bus.o_ro_err),   64'h0);
        check("wdog_cyc",    64'(bus.o_wb_cyc),   64'h0);
        check("wdog_stall",  64'(bus.o_ro_stall), 64'h1);
        tick();
        tick();
        check("err_hold", 64'(bus.o_grant), 64'h0);
        bus.i_ro_cyc = 1'b0;
        tick();
        bus.i_ro_cyc = 1'b1;
        tick();
        check("err_exit_regrant", 64'(bus.o_grant), 64'h2);

        // Bus error on an RW write, with a simultaneous ack.
        do_reset();
        bus.i_rw_cyc = 1'b1;
        tick();
        bus.i_rw_stb  = 1'b1;
        bus.i_rw_we   = 1'b1;
        bus.i_rw_addr = 32'h1000_0008;
        bus.i_rw_data = 64'h0123_4567_89AB_CDEF;
        bus.i_rw_be   = 8'h0F;
        #1;
        check("wr_we",   64'(bus.o_wb_we), 64'h1);
        check("wr_data", bus.o_wb_data,    64'h0123_4567_89AB_CDEF);
        check("wr_be",   64'(bus.o_wb_be), 64'h0F);
        tick();
        bus.i_rw_stb = 1'b0;
        bus.i_wb_err = 1'b1;
        bus.i_wb_ack = 1'b1;
        #1;
        check("err_fwd",     64'(bus.o_rw_err), 64'h1);
        check("err_ack_fwd", 64'(bus.o_rw_ack), 64'h1);
        check("err_ro_quiet", 64'(bus.o_ro_err), 64'h0);
        tick();
        bus.i_wb_err = 1'b0;
        bus.i_wb_ack = 1'b0;
        bus.i_rw_stb = 1'b1;
        #1;
        check("err_stall", 64'(bus.o_rw_stall), 64'h1);
        check("err_cyc",   64'(bus.o_wb_cyc),   64'h0);
        tick();
        check("err_stall2", 64'(bus.o_rw_stall), 64'h1);
        bus.i_rw_cyc = 1'b0;
        tick();
        bus.i_rw_cyc = 1'b1;
        tick();
        check("err_recover_stall", 64'(bus.o_rw_stall), 64'h0);
        check("err_recover_stb",   64'(bus.o_wb_stb),   64'h1);

        // Asynchronous reset with two requests outstanding.
        do_reset();
        bus.i_rw_cyc = 1'b1;
        tick();
        bus.i_rw_stb = 1'b1;
        tick();
        tick();
        bus.i_rw_stb = 1'b0;
        #1;
        check("pre_rst_cyc", 64'(bus.o_wb_cyc), 64'h1);
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_cyc",    64'(bus.o_wb_cyc), 64'h0);
        check("arst_stalls", 64'({bus.o_rw_stall, bus.o_ro_stall}), 64'h3);
        bus.i_rw_cyc = 1'b0;
        bus.i_wb_ack = 1'b1;
        #1;
        check("arst_ack", 64'({bus.o_rw_ack, bus.o_ro_ack}), 64'h0);
        tick();
        i_reset = 1'b0;
        #1;
        check("post_rst_ack", 64'({bus.o_rw_ack, bus.o_ro_ack}), 64'h0);
        bus.i_wb_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
